// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encoding plus the types and helpers used by the
// iterative multiply/divide unit (muldiv_unit, muldiv_step).
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  // RV32M funct3 encoding
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input muldiv_op_t op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_signed_b(input muldiv_op_t op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the unit: a shift-add multiply step or a
// restoring-division step on a shared 2*XLEN accumulator.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              i_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_acc,
  output logic              o_q_bit
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_trial;

  // Multiply: upper half accumulates the multiplicand, lower half holds the
  // remaining multiplier bits. Divide: upper half is the partial remainder,
  // lower half shifts dividend bits out and quotient bits in.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    o_acc   = i_acc;
    o_q_bit = 1'b0;
    w_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opnd};
    w_shift = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
    w_trial = w_shift - {1'b0, i_opnd};
    if (i_div) begin
      o_q_bit = ~w_trial[XLEN];
      o_acc   = {(o_q_bit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0]),
                 i_acc[XLEN-2:0], 1'b0};
    end else if (i_acc[0]) begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a start/busy/done handshake.
// Define MULDIV_FAST_PATH_EN to finish divide-by-zero and signed overflow in one cycle.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW       = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     r_state;
  muldiv_op_t        r_op;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_a_orig;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic              r_div_zero;
  logic              r_ovf;

  muldiv_op_t        w_op_in;
  logic              w_is_div_in;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic              w_b_zero;
  logic              w_ovf_in;
  logic              w_skip;
  logic              w_is_div;
  logic [2*XLEN-1:0] w_acc_next;
  logic              w_q_bit;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_result;

  assign w_op_in     = muldiv_op_t'(op);
  assign w_is_div_in = is_div(w_op_in);
  assign w_neg_a     = is_signed_a(w_op_in) & a[XLEN-1];
  assign w_neg_b     = is_signed_b(w_op_in) & b[XLEN-1];
  assign w_a_abs     = w_neg_a ? -a : a;
  assign w_b_abs     = w_neg_b ? -b : b;
  assign w_b_zero    = (b == '0);
  assign w_ovf_in    = w_is_div_in & is_signed_b(w_op_in) & (a == MOST_NEG) & (b == '1);
  assign w_is_div    = is_div(r_op);

`ifdef MULDIV_FAST_PATH_EN
  assign w_skip = w_is_div_in & (w_b_zero | w_ovf_in);
`else
  assign w_skip = 1'b0;
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_div   (w_is_div),
    .i_acc   (r_acc),
    .i_opnd  (r_opnd),
    .o_acc   (w_acc_next),
    .o_q_bit (w_q_bit)
  );

  // Sign correction and special cases; remainder follows the dividend's sign.
  always_comb begin
    w_prod       = r_neg_res ? -r_acc : r_acc;
    w_quo        = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem        = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    w_fix_result = '0;
    case (r_op)
      MUL:                  w_fix_result = w_prod[XLEN-1:0];
      MULH, MULHSU, MULHU:  w_fix_result = w_prod[2*XLEN-1:XLEN];
      DIV, DIVU:            w_fix_result = r_div_zero ? '1 : (r_ovf ? MOST_NEG : w_quo);
      REM, REMU:            w_fix_result = r_div_zero ? r_a_orig : (r_ovf ? '0 : w_rem);
      default:              w_fix_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_op       <= MUL;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_a_orig   <= '0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op       <= w_op_in;
            r_cnt      <= CNT_INIT;
            r_opnd     <= w_is_div_in ? w_b_abs : w_a_abs;
            r_acc      <= {{XLEN{1'b0}}, (w_is_div_in ? w_a_abs : w_b_abs)};
            r_a_orig   <= a;
            r_neg_res  <= w_neg_a ^ w_neg_b;
            r_neg_rem  <= w_neg_a;
            r_div_zero <= w_is_div_in & w_b_zero;
            r_ovf      <= w_ovf_in;
            busy       <= 1'b1;
            r_state    <= w_skip ? FIX : CALC;
          end
        end
        CALC: begin
          r_acc <= w_acc_next | {{(2*XLEN-1){1'b0}}, w_q_bit};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          result  <= w_fix_result;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, abort/reuse,
// back-to-back and randomized operations against a 64-bit arithmetic model.
module tb_muldiv_unit;
  import cpu_pkg::*;

  localparam int          XLEN     = 32;
  localparam logic [31:0] MOST_NEG = 32'h8000_0000;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] fop, input logic [31:0] x,
                                            input logic [31:0] y);
    longint      sx, sy, sq;
    logic [63:0] p;
    logic        ovf;
    sx  = $signed(x);
    sy  = $signed(y);
    ovf = (x == MOST_NEG) && (y == 32'hFFFF_FFFF);
    case (muldiv_op_t'(fop))
      MUL:    begin p = {32'b0, x} * {32'b0, y}; return p[31:0];  end
      MULH:   begin p = sx * sy;                 return p[63:32]; end
      MULHSU: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
      MULHU:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf)    return MOST_NEG;
        sq = sx / sy; return sq[31:0];
      end
      DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      REM: begin
        if (y == 0) return x;
        if (ovf)    return 32'h0;
        sq = sx % sy; return sq[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] fop, input logic [31:0] x,
                                     input logic [31:0] y);
    logic special;
    special = fop[2] && ((y == 0) ||
              ((fop == DIV || fop == REM) && x == MOST_NEG && y == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_PATH_EN
    return special ? 1 : XLEN + 1;
`else
    return (special === 1'bx) ? 0 : XLEN + 1;
`endif
  endfunction

  // Called #1 after a clock edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [2:0] fop, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = fop;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Counts edges after the accepting edge until done; optionally pulses start mid-operation.
  task automatic wait_done(input int pulse_at, output logic [31:0] res, output int lat,
                           output bit busy_ok);
    lat     = 0;
    res     = 'x;
    busy_ok = (busy === 1'b1);
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (c == pulse_at) begin
        start = 1'b1;
        op    = DIV;
        a     = 32'd100;
        b     = 32'd200;
      end else if (c == pulse_at + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = c;
        res = result;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] fop, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_res);
    logic [31:0] res;
    int          lat;
    bit          busy_ok;
    start_op(fop, x, y);
    wait_done(0, res, lat, busy_ok);
    check({tag, "_result"}, res, exp_res);
    check({tag, "_latency"}, lat, exp_latency(fop, x, y));
    check({tag, "_busy"}, busy_ok, 1);
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    bit          busy_ok;
    bit          saw_done;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          kind;

    reset_n = 1'b0;
    start   = 1'b0;
    op      = '0;
    a       = '0;
    b       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul_4x2", MUL, 32'd4, 32'd2, 32'd8);
    @(posedge clk);
    #1;
    check("done_pulse_width", done, 0);
    check("result_hold", result, 32'd8);

    run_op("mulhu_ff", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulh_ff", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_op("div_m7_2", DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_m7_2", REM, -32'sd7, 32'd2, 32'hFFFF_FFFF);
    run_op("divu_7_2", DIVU, 32'd7, 32'd2, 32'd3);
    run_op("remu_7_2", REMU, 32'd7, 32'd2, 32'd1);
    run_op("divu_by0", DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_by0", REMU, 32'd7, 32'd0, 32'd7);
    run_op("rem_by0_neg", REM, -32'sd9, 32'd0, 32'hFFFF_FFF7);
    run_op("div_ovf", DIV, MOST_NEG, 32'hFFFF_FFFF, MOST_NEG);
    run_op("rem_ovf", REM, MOST_NEG, 32'hFFFF_FFFF, 32'h0);

    // start pulsed mid-operation must be ignored
    start_op(MUL, 32'd3, 32'd5);
    wait_done(10, res, lat, busy_ok);
    check("ignore_start_result", res, 32'd15);
    check("ignore_start_latency", lat, XLEN + 1);
    check("ignore_start_busy", busy_ok, 1);

    // reset in the middle of a divide discards it
    start_op(DIV, -32'sd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("mul_6x7", MUL, 32'd6, 32'd7, 32'd42);

    // back-to-back: run_op returns in the done cycle, so this start is in it
    run_op("b2b_first", MUL, 32'd9, 32'd9, 32'd81);
    run_op("b2b_second", DIVU, 32'd100, 32'd7, 32'd14);

    for (int i = 0; i < 40; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = $urandom;
      rb   = $urandom;
      kind = $urandom_range(0, 7);
      if (kind == 0) rb = 32'h0;
      else if (kind == 1) begin
        ra = MOST_NEG;
        rb = 32'hFFFF_FFFF;
      end else if (kind == 2) rb = $urandom_range(1, 5);
      else if (kind == 3) ra = -ra;
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ref_model(rop, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
